// File: rtl/dvsi_scan_ctrl.sv
// dvsi_scan_ctrl: scan sequencer and event capture for the DVSI sensor.
// Drives row/column scan clocks and sensor resets, samples P columns of
// ON/OFF polarity per column clock and buffers non-empty samples in a FIFO.
//
// state  | meaning
// IDLE   | sensor held in reset, waiting for en_i
// RESET  | sensor reset pulse, RST_CYCLES long
// YHI    | row clock high, DIV long
// YLO    | row clock low, DIV long
// XHI    | column clock high, DIV long
// XLO    | column clock low, DIV long
// SAMPLE | capture one column group, 1 cycle
// DONE   | frame end pulse, 1 cycle
module dvsi_scan_ctrl #(
  parameter int ROWS       = 64,
  parameter int COLS       = 64,
  parameter int P          = 4,
  parameter int DIV        = 4,
  parameter int RST_CYCLES = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int G          = COLS / P,
  parameter int RW         = $clog2(ROWS),
  parameter int CW         = (G > 1) ? $clog2(G) : 1,
  parameter int EW         = RW + CW + 2 * P
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [7:0]    cfg_i,
  output logic [7:0]    dvsi_cfg_o,
  output logic          dvsi_xclk_o,
  output logic          dvsi_yclk_o,
  output logic          dvsi_xnrst_o,
  output logic          dvsi_ynrst_o,
  input  logic [P-1:0]  dvsi_on_i,
  input  logic [P-1:0]  dvsi_off_i,
  output logic          evt_valid_o,
  input  logic          evt_ready_i,
  output logic [EW-1:0] evt_data_o,
  output logic          frame_done_o,
  output logic          busy_o,
  output logic [15:0]   ovf_cnt_o
);

  localparam int TMAX = (RST_CYCLES > DIV) ? RST_CYCLES : DIV;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_YHI, S_YLO, S_XHI, S_XLO, S_SAMPLE, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer;
  logic [RW-1:0] row;
  logic [CW-1:0] col;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push_req, push_ok, pop, full;

  // Next-state decode; timed states leave when the down-counter reaches zero.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (en_i) state_n = S_RESET;
      S_RESET:  if (timer == '0) state_n = S_YHI;
      S_YHI:    if (timer == '0) state_n = S_YLO;
      S_YLO:    if (timer == '0) state_n = S_XHI;
      S_XHI:    if (timer == '0) state_n = S_XLO;
      S_XLO:    if (timer == '0) state_n = S_SAMPLE;
      S_SAMPLE: begin
        if (col != CW'(G - 1))       state_n = S_XHI;
        else if (row != RW'(ROWS - 1)) state_n = S_YHI;
        else                         state_n = S_DONE;
      end
      S_DONE:   state_n = en_i ? S_RESET : S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Scan FSM with timer, scan counters, cfg latch and outputs registered from next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      timer        <= '0;
      row          <= '0;
      col          <= '0;
      dvsi_cfg_o   <= '0;
      dvsi_xclk_o  <= 1'b0;
      dvsi_yclk_o  <= 1'b0;
      dvsi_xnrst_o <= 1'b0;
      dvsi_ynrst_o <= 1'b0;
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state)
        timer <= (state_n == S_RESET) ? TW'(RST_CYCLES - 1) : TW'(DIV - 1);
      else if (timer != '0)
        timer <= timer - 1'b1;

      // RESET is only entered from IDLE or DONE, the two cfg capture points.
      if (state_n == S_RESET && state != S_RESET) begin
        row        <= '0;
        col        <= '0;
        dvsi_cfg_o <= cfg_i;
      end else if (state == S_SAMPLE) begin
        if (state_n == S_XHI) begin
          col <= col + 1'b1;
        end else if (state_n == S_YHI) begin
          row <= row + 1'b1;
          col <= '0;
        end
      end

      dvsi_xclk_o  <= (state_n == S_XHI);
      dvsi_yclk_o  <= (state_n == S_YHI);
      dvsi_xnrst_o <= (state_n != S_IDLE) && (state_n != S_RESET);
      dvsi_ynrst_o <= (state_n != S_IDLE) && (state_n != S_RESET);
      frame_done_o <= (state_n == S_DONE);
      busy_o       <= (state_n != S_IDLE);
    end
  end

  assign full     = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop      = (count != '0) && evt_ready_i;
  assign push_req = (state == S_SAMPLE) && ((dvsi_on_i | dvsi_off_i) != '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);

  assign evt_valid_o = (count != '0);
  assign evt_data_o  = evt_valid_o ? mem[rd_ptr] : '0;

  // Event FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf_cnt_o <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {row, col, dvsi_on_i, dvsi_off_i};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)
        count <= count + 1'b1;
      else if (!push_ok && pop)
        count <= count - 1'b1;
      if (push_req && !push_ok && ovf_cnt_o != 16'hFFFF)
        ovf_cnt_o <= ovf_cnt_o + 1'b1;
    end
  end

endmodule

// File: doc/dvsi_scan_ctrl.md
# dvsi_scan_ctrl

Parametrised scan sequencer and event capture for the dynamic-vision sensor attached to the FPGA mezzanine DVSI pads. It generates the row/column scan clocks and active-low resets, drives the configuration pins, and samples the per-column ON/OFF polarity lines. Non-empty samples are packed into event words and buffered in a FIFO toward the SoC-side consumer. It sits between the pad ring and the DVSI peripheral. It generalises the fixed 4-ON/4-OFF, 8-cfg pad mapping to configurable array size, column parallelism, scan rate and buffer depth.

## Interface
- ROWS, 64: sensor rows; power of 2, ≥2.
- COLS, 64: sensor columns; power of 2, multiple of P.
- P, 4: columns sampled per xclk (width of on/off buses).
- DIV, 4: half-period of xclk/yclk in clk_i cycles; ≥1.
- RST_CYCLES, 8: sensor reset length in clk_i cycles; ≥1.
- FIFO_DEPTH, 16: event buffer entries; power of 2, ≥2.
- Derived: G = COLS/P, RW = clog2(ROWS), CW = clog2(G) (min 1), EW = RW+CW+2P.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  scan enable.
- cfg_i  in  8  sensor configuration word.
- dvsi_cfg_o  out  8  registered cfg to pads.
- dvsi_xclk_o, dvsi_yclk_o  out  1  column/row scan clocks.
- dvsi_xnrst_o, dvsi_ynrst_o  out  1  active-low sensor resets.
- dvsi_on_i, dvsi_off_i  in  P  polarity lines, already synchronised.
- evt_valid_o  out  1  FIFO head valid.
- evt_ready_i  in  1  consumer accepts head.
- evt_data_o  out  EW  {row, col_group, on, off}.
- frame_done_o  out  1  one-cycle pulse at frame end.
- busy_o  out  1  FSM not IDLE.
- ovf_cnt_o  out  16  dropped-event counter, saturating.

## Operation
- FSM states:
  - IDLE → RESET when en_i=1.
  - RESET: RST_CYCLES cycles → YHI.
  - YHI: DIV cycles → YLO.
  - YLO: DIV cycles → XHI.
  - XHI: DIV cycles → XLO.
  - XLO: DIV cycles → SAMPLE.
  - SAMPLE: 1 cycle → XHI if col_group<G-1, else YHI if row<ROWS-1, else DONE.
  - DONE: 1 cycle → RESET if en_i=1, else IDLE.
- Reset lines:
  - dvsi_xnrst_o/dvsi_ynrst_o = 0 in IDLE and RESET; 1 otherwise.
- Scan clocks:
  - dvsi_yclk_o = 1 only in YHI; dvsi_xclk_o = 1 only in XHI. All outputs are registered from the state.
- Counters:
  - row and col_group clear on entering RESET.
  - row increments on leaving SAMPLE to YHI.
  - col_group increments on leaving SAMPLE to XHI and clears on leaving SAMPLE to YHI.
- Configuration:
  - dvsi_cfg_o latches cfg_i on the IDLE→RESET and DONE→RESET transitions only.
- Sampling:
  - In SAMPLE, if (dvsi_on_i | dvsi_off_i) ≠ 0, push {row, col_group, dvsi_on_i, dvsi_off_i}.
- FIFO:
  - Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and ovf_cnt_o increments, saturating at 0xFFFF.
  - Pop occurs when evt_valid_o & evt_ready_i.
  - Push and pop in the same cycle on an empty FIFO: no bypass; the pushed word appears next cycle.
- en_i deasserted mid-frame: the frame completes. en_i is checked only in IDLE and DONE.
- frame_done_o = 1 exactly in DONE.

## Timing
- Reset values:
  - All outputs 0, including xnrst/ynrst (sensor held in reset).
  - FIFO empty, counters 0, state IDLE.
- busy_o is 1 from the cycle after en_i is sampled high in IDLE.
- Frame length from RESET entry through DONE inclusive: RST_CYCLES + ROWS·(2·DIV + G·(2·DIV+1)) + 1 cycles.
- Event latency: evt_valid_o rises the cycle after SAMPLE when the FIFO was empty.
- evt_data_o is stable while evt_valid_o=1 and evt_ready_i=0.
- Back-to-back frames have no IDLE gap: DONE→RESET.

## Test plan
Parameters for all scenarios: ROWS=2, COLS=8, P=4, DIV=1, RST_CYCLES=2, FIFO_DEPTH=4, so G=2 and the frame is 19 cycles.
- Reset/startup:
  - Stimulus: rst_i for 3 cycles, then en_i=1 at cycle t.
  - Required: all outputs 0 during reset. nrst lines 0 in t+1..t+2 and 1 at t+3. First yclk high at t+3. dvsi_cfg_o equals cfg_i captured at t.
- Quiet frame:
  - Stimulus: on/off=0, en_i pulsed for one cycle.
  - Required: exactly 2 yclk and 4 xclk pulses. frame_done_o high at t+19, never earlier. No evt_valid_o. Then IDLE, busy_o=0, nrst=0.
- Single event:
  - Stimulus: on=4'b0101 only in the SAMPLE of row 1, group 1.
  - Required: one event, evt_data_o={1,1,4'b0101,4'b0000}, valid the cycle after that SAMPLE. Held until ready.
- Overflow:
  - Stimulus: evt_ready_i=0, on=4'hF continuously, two frames.
  - Required: first 4 events stored in order (row,group) 00,01,10,11. ovf_cnt_o=4 after frame 2.
- Full push/pop:
  - Stimulus: FIFO full, evt_ready_i=1 in a SAMPLE cycle with activity.
  - Required: the event is accepted, ovf_cnt_o unchanged, FIFO remains full.
- Mid-frame disable plus reset:
  - Stimulus: en_i dropped during row 0.
  - Required: frame completes and frame_done_o pulses before IDLE.
  - Follow-up: rst_i asserted during XHI returns all outputs to reset values the next cycle and the FIFO is emptied.
